// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : timer_pkg
//  Description : Shared definitions for the timer configuration port:
//                arbiter state encoding, port widths, register map and a
//                helper for sizing requester index fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

   // Timer configuration port geometry
   localparam int TIMER_CFG_ADDR_W = 3;
   localparam int TIMER_CFG_DATA_W = 8;

   // Timer configuration register map
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_CTRL    = 3'd0;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_PRESCL  = 3'd1;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_LOAD_LO = 3'd2;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_LOAD_HI = 3'd3;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_CMP_LO  = 3'd4;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_CMP_HI  = 3'd5;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_IRQ_EN  = 3'd6;
   localparam logic [TIMER_CFG_ADDR_W-1:0] TMR_REG_STATUS  = 3'd7;

   // Transaction sequencer states: one cycle each except IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   // Width of a requester index; a single requester still needs one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_cfg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Grants the first set
//                request bit at or after ptr, wrapping past N-1 to 0.
//                Produces a one-hot grant and the matching index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import timer_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   // Rotating a doubled copy puts the pointer position at bit 0
   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;

   // Rotate the request vector so search order starts at ptr
   always_comb begin
      w_dbl = {req, req} >> ptr;
      w_rot = w_dbl[N-1:0];
   end

   // Scan rotated requests; first hit wins, mapped back to real position
   always_comb begin
      int   pos;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int off = 0; off < N; off++) begin
         if (!found && w_rot[off]) begin
            found = 1'b1;
            pos   = int'(ptr) + off;
            if (pos >= N) begin
               pos = pos - N;
            end
            idx   = IDX_W'(pos);
            grant = N'(1) << pos;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/timer_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_cfg_arbiter
//  Description : Shares the timer's single configuration port among N_REQ
//                requesters with round-robin arbitration. Each transaction
//                takes a fixed four cycles (IDLE, ISSUE, WAIT, DONE) and
//                writes may be blocked per requester/address by PROT_MASK.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_cfg_arbiter
   import timer_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = TIMER_CFG_ADDR_W,
   parameter int DATA_W = TIMER_CFG_DATA_W,
   parameter logic [N_REQ*(2**ADDR_W)-1:0] PROT_MASK = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          ack,
   output logic                      err,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         config_address,
   output logic                      config_write_enable,
   output logic [DATA_W-1:0]         write_data,
   input  logic [DATA_W-1:0]         read_data
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam int NA    = 2**ADDR_W;

   arb_state_t state_q, state_d;

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              we_q, we_d;
   logic              prot_q, prot_d;

   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
   logic              cfg_we_q, cfg_we_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [N_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_any_req;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [NA-1:0]     w_prot_row;
   logic              w_sel_prot;

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (w_grant),
      .idx   (w_pick_idx)
   );

   // Select the winner's fields through the one-hot grant and look up protection
   always_comb begin
      w_any_req   = |req;
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_we    = w_sel_we    | req_we[i];
            w_sel_addr  = w_sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = w_sel_wdata | req_wdata[i*DATA_W +: DATA_W];
         end
      end
      w_prot_row = NA'(PROT_MASK >> (NA * int'(w_pick_idx)));
      w_sel_prot = w_prot_row[w_sel_addr];
   end

   // State and all registered outputs; reset drops any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         we_q       <= 1'b0;
         prot_q     <= 1'b0;
         ack_q      <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         cfg_addr_q <= '0;
         cfg_we_q   <= 1'b0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         we_q       <= we_d;
         prot_q     <= prot_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         cfg_addr_q <= cfg_addr_d;
         cfg_we_q   <= cfg_we_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Next-state: fixed walk through ISSUE/WAIT/DONE once a request is granted
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (w_any_req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values, computed for the state being entered
   always_comb begin
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      we_d       = we_q;
      prot_d     = prot_q;
      ack_d      = '0;
      err_d      = 1'b0;
      rdata_d    = rdata_q;
      cfg_addr_d = cfg_addr_q;
      cfg_we_d   = 1'b0;
      wr_data_d  = wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (w_any_req) begin
               // Latch the winner so later req/field changes cannot disturb it
               idx_d      = w_pick_idx;
               we_d       = w_sel_we;
               prot_d     = w_sel_prot;
               cfg_addr_d = w_sel_addr;
               cfg_we_d   = w_sel_we & ~w_sel_prot;
               wr_data_d  = w_sel_wdata;
            end
         end
         ST_WAIT: begin
            // Timer read data has had its one cycle of latency by now
            ack_d = N_REQ'(1) << idx_q;
            err_d = we_q & prot_q;
            if (!we_q) begin
               rdata_d = read_data;
            end
         end
         ST_DONE: begin
            if (idx_q == IDX_W'(N_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign ack                 = ack_q;
   assign err                 = err_q;
   assign rdata               = rdata_q;
   assign config_address      = cfg_addr_q;
   assign config_write_enable = cfg_we_q;
   assign write_data          = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_cfg_arbiter
//  Description : Self-checking bench for timer_cfg_arbiter with a small
//                timer register model behind the configuration port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_cfg_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [1:0] req_we;
   logic [5:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0] ack;
   logic       err;
   logic [7:0] rdata;
   logic [2:0] config_address;
   logic       config_write_enable;
   logic [7:0] write_data;
   logic [7:0] read_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Requester 1 may not write address 0
   timer_cfg_arbiter #(
      .N_REQ     (2),
      .ADDR_W    (3),
      .DATA_W    (8),
      .PROT_MASK (16'h0100)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req                 (req),
      .req_we              (req_we),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .ack                 (ack),
      .err                 (err),
      .rdata               (rdata),
      .config_address      (config_address),
      .config_write_enable (config_write_enable),
      .write_data          (write_data),
      .read_data           (read_data)
   );

   always #5 clk = ~clk;

   // Timer register model: registered write, registered read
   logic [7:0] tmr_regs [8];
   initial begin
      for (int i = 0; i < 8; i++) tmr_regs[i] = 8'h10 + 8'(i);
      tmr_regs[2] = 8'h3C;
      read_data   = 8'h00;
   end
   always @(posedge clk) begin
      if (config_write_enable) tmr_regs[config_address] <= write_data;
      read_data <= tmr_regs[config_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] req;
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [1:0] exp_ack;
      logic       exp_err;
      logic [7:0] exp_rdata;
      int         exp_wr;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int         wr_cnt, ack_cnt, ack_s, last_ack, nack;
      logic [2:0] wr_addr;
      logic [7:0] wr_data;
      logic [1:0] ack_v;
      logic       err_v;
      logic [7:0] rd_v;
      int         cnt [2];
      logic [1:0] order [4];

      //            req    we    addr  wdata  ack    err   rdata  wr
      vecs[0] = '{2'b01, 1'b1, 3'd3, 8'hA5, 2'b01, 1'b0, 8'h00, 1};
      vecs[1] = '{2'b10, 1'b0, 3'd2, 8'h00, 2'b10, 1'b0, 8'h3C, 0};
      vecs[2] = '{2'b10, 1'b1, 3'd0, 8'h5A, 2'b10, 1'b1, 8'h3C, 0};
      vecs[3] = '{2'b01, 1'b1, 3'd0, 8'h77, 2'b01, 1'b0, 8'h3C, 1};
      vecs[4] = '{2'b01, 1'b0, 3'd0, 8'h00, 2'b01, 1'b0, 8'h77, 0};
      vecs[5] = '{2'b10, 1'b0, 3'd3, 8'h00, 2'b10, 1'b0, 8'hA5, 0};
      vecs[6] = '{2'b10, 1'b1, 3'd7, 8'hC3, 2'b10, 1'b0, 8'hA5, 1};
      vecs[7] = '{2'b01, 1'b0, 3'd7, 8'h00, 2'b01, 1'b0, 8'hC3, 0};

      rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ack",   32'(ack), 0);
      chk("reset_err",   32'(err), 0);
      chk("reset_rdata", 32'(rdata), 0);
      chk("reset_addr",  32'(config_address), 0);
      chk("reset_we",    32'(config_write_enable), 0);
      chk("reset_wdata", 32'(write_data), 0);

      // Table: one transaction each, req pulsed for a single cycle
      for (int v = 0; v < 8; v++) begin
         // Non-winning requester gets conflicting fields
         req_we    = vecs[v].req[0] ? {~vecs[v].we, vecs[v].we} : {vecs[v].we, ~vecs[v].we};
         req_addr  = vecs[v].req[0] ? {3'd6, vecs[v].addr}    : {vecs[v].addr, 3'd6};
         req_wdata = vecs[v].req[0] ? {8'hFF, vecs[v].wdata}  : {vecs[v].wdata, 8'hFF};
         req = vecs[v].req;
         wr_cnt = 0; ack_cnt = 0; ack_s = -1;
         wr_addr = '0; wr_data = '0; ack_v = '0; err_v = 1'b0; rd_v = '0;
         for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (s == 0) req = '0;
            if (config_write_enable) begin
               wr_cnt++; wr_addr = config_address; wr_data = write_data;
            end
            if (ack != 0) begin
               ack_cnt++; ack_s = s; ack_v = ack; err_v = err; rd_v = rdata;
            end
         end
         chk($sformatf("v%0d_ack", v),      32'(ack_v), 32'(vecs[v].exp_ack));
         chk($sformatf("v%0d_ack_cyc", v),  32'(ack_s), 2);
         chk($sformatf("v%0d_ack_cnt", v),  32'(ack_cnt), 1);
         chk($sformatf("v%0d_err", v),      32'(err_v), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_rdata", v),    32'(rd_v), 32'(vecs[v].exp_rdata));
         chk($sformatf("v%0d_wr_cnt", v),   32'(wr_cnt), 32'(vecs[v].exp_wr));
         if (vecs[v].exp_wr == 1) begin
            chk($sformatf("v%0d_wr_addr", v), 32'(wr_addr), 32'(vecs[v].addr));
            chk($sformatf("v%0d_wr_data", v), 32'(wr_data), 32'(vecs[v].wdata));
         end
      end
      chk("blocked_reg0_kept", 32'(tmr_regs[0]), 32'h77);

      // Reset during WAIT: outputs clear, no ack, issued write remains
      req_we = 2'b01; req_addr = {3'd0, 3'd5}; req_wdata = {8'h00, 8'h11};
      req = 2'b01;
      @(negedge clk);
      req = '0;
      chk("rstwait_issue_we", 32'(config_write_enable), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstwait_ack",   32'(ack), 0);
      chk("rstwait_err",   32'(err), 0);
      chk("rstwait_rdata", 32'(rdata), 0);
      chk("rstwait_addr",  32'(config_address), 0);
      chk("rstwait_we",    32'(config_write_enable), 0);
      chk("rstwait_wdata", 32'(write_data), 0);
      nack = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack != 0) nack++;
      end
      chk("rstwait_no_ack", 32'(nack), 0);
      chk("rstwait_reg5", 32'(tmr_regs[5]), 32'h11);

      // Contention: both hold req, two reads each; grants must alternate from 0
      req_we = 2'b00; req_addr = {3'd2, 3'd3}; req_wdata = '0;
      cnt[0] = 2; cnt[1] = 2; nack = 0; last_ack = -100;
      req = 2'b11;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ack != 0) begin
            if (nack < 4) order[nack] = ack;
            chk("cont_gap", 32'(c - last_ack >= 4), 1);
            chk("cont_rdata", 32'(rdata), ack[0] ? 32'hA5 : 32'h3C);
            last_ack = c;
            nack++;
            for (int r = 0; r < 2; r++) begin
               if (ack[r]) begin
                  cnt[r]--;
                  if (cnt[r] == 0) req[r] = 1'b0;
               end
            end
         end
      end
      req = '0;
      chk("cont_nack", 32'(nack), 4);
      if (nack >= 4) begin
         chk("cont_g0", 32'(order[0]), 32'h1);
         chk("cont_g1", 32'(order[1]), 32'h2);
         chk("cont_g2", 32'(order[2]), 32'h1);
         chk("cont_g3", 32'(order[3]), 32'h2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
